// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN reward-window stage.
// The decision margin is enabled at build time with SNN_REWARD_MARGIN_EN.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COUNT  = 2'b01,
    DECIDE = 2'b10,
    REPORT = 2'b11
  } state_t;

  typedef logic [1:0] reward_t;
  localparam reward_t REW_POS  = 2'b01;
  localparam reward_t REW_ZERO = 2'b00;
  localparam reward_t REW_NEG  = 2'b11;

  typedef logic [1:0] winner_t;
  localparam winner_t WIN_NONE = 2'b00;
  localparam winner_t WIN_A    = 2'b01;
  localparam winner_t WIN_B    = 2'b10;

  // Target 0 means class A is expected, target 1 means class B.
  function automatic reward_t score(input winner_t w, input logic tgt);
    if (w == WIN_NONE)
      return REW_ZERO;
    else if ((w == WIN_B) == tgt)
      return REW_POS;
    else
      return REW_NEG;
  endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// Saturating up-counter with synchronous clear; ena freezes it completely.
module snn_spike_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr)
        cnt <= '0;
      else if (inc && (cnt != CNT_MAX))
        cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/snn_reward_window.sv
// Counts A/B spikes over WINDOW valid samples, picks a winner and reports a reward.
// Build option: SNN_REWARD_MARGIN_EN requires |cnt_a-cnt_b| >= MARGIN for a winner.
module snn_reward_window
  import snn_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             target,
  input  logic             in_valid,
  input  logic             spike_a,
  input  logic             spike_b,
  output logic             rew_valid,
  input  logic             rew_ready,
  output logic [1:0]       reward,
  output logic [1:0]       winner,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             busy
);

  localparam int SW = $clog2(WINDOW + 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(WINDOW - 1);

`ifdef SNN_REWARD_MARGIN_EN
  localparam bit MARGIN_ON = 1'b1;
`else
  localparam bit MARGIN_ON = 1'b0;
`endif
  // Without the margin option only an exact tie is indecisive.
  localparam logic [CNT_W:0] MIN_GAP = (CNT_W + 1)'(MARGIN_ON ? MARGIN : 1);

  state_t          state;
  logic            target_q;
  winner_t         win_res;
  reward_t         rew_res;
  logic [SW-1:0]   sample_cnt;
  logic            start_in_idle;
  logic            sample_in;
  logic [CNT_W:0]  diff;
  winner_t         decide_win;

  assign start_in_idle = (state == IDLE) && start;
  assign sample_in     = (state == COUNT) && in_valid;

  snn_spike_counter #(.W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (start_in_idle),
    .inc   (sample_in && spike_a),
    .cnt   (cnt_a)
  );

  snn_spike_counter #(.W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (start_in_idle),
    .inc   (sample_in && spike_b),
    .cnt   (cnt_b)
  );

  snn_spike_counter #(.W(SW)) u_samples (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (start_in_idle),
    .inc   (sample_in),
    .cnt   (sample_cnt)
  );

  always_comb begin
    diff       = '0;
    decide_win = WIN_NONE;
    if (cnt_a >= cnt_b)
      diff = {1'b0, cnt_a} - {1'b0, cnt_b};
    else
      diff = {1'b0, cnt_b} - {1'b0, cnt_a};
    if ((diff == '0) || (diff < MIN_GAP))
      decide_win = WIN_NONE;
    else if (cnt_a > cnt_b)
      decide_win = WIN_A;
    else
      decide_win = WIN_B;
  end

  // REPORT spends its first cycle presenting the results registered in DECIDE,
  // so rew_valid rises on the second edge after the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target_q  <= 1'b0;
      win_res   <= WIN_NONE;
      rew_res   <= REW_ZERO;
      rew_valid <= 1'b0;
      winner    <= WIN_NONE;
      reward    <= REW_ZERO;
      busy      <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            target_q <= target;
            busy     <= 1'b1;
            state    <= COUNT;
          end
        end
        COUNT: begin
          if (in_valid && (sample_cnt == LAST_IDX))
            state <= DECIDE;
        end
        DECIDE: begin
          win_res <= decide_win;
          rew_res <= score(decide_win, target_q);
          state   <= REPORT;
        end
        REPORT: begin
          if (rew_valid && rew_ready) begin
            rew_valid <= 1'b0;
            winner    <= WIN_NONE;
            reward    <= REW_ZERO;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (!rew_valid) begin
            rew_valid <= 1'b1;
            winner    <= win_res;
            reward    <= rew_res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_reward_window.sv
// Directed bench for snn_reward_window: window-level model plus per-cycle report checker.
module tb_snn_reward_window;

  localparam int WINDOW = 16;
  localparam int CNT_W  = 8;
  localparam int MARGIN = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, ena, start, target, in_valid, spike_a, spike_b, rew_ready;
  logic             rew_valid, busy;
  logic [1:0]       reward, winner;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  logic       s_start, s_target, s_in_valid, s_spike_a, s_spike_b, s_rew_ready;
  logic       s_rew_valid, s_busy;
  logic [1:0] s_reward, s_winner;
  logic [2:0] s_cnt_a, s_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  int         exp_a, exp_b;
  logic [1:0] exp_win, exp_rew;

  always #5 clk = ~clk;

  snn_reward_window #(.WINDOW(WINDOW), .CNT_W(CNT_W), .MARGIN(MARGIN)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .target(target),
    .in_valid(in_valid), .spike_a(spike_a), .spike_b(spike_b),
    .rew_valid(rew_valid), .rew_ready(rew_ready), .reward(reward), .winner(winner),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .busy(busy)
  );

  snn_reward_window #(.WINDOW(7), .CNT_W(3), .MARGIN(MARGIN)) dut_small (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(s_start), .target(s_target),
    .in_valid(s_in_valid), .spike_a(s_spike_a), .spike_b(s_spike_b),
    .rew_valid(s_rew_valid), .rew_ready(s_rew_ready), .reward(s_reward), .winner(s_winner),
    .cnt_a(s_cnt_a), .cnt_b(s_cnt_b), .busy(s_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Window-level model: counts, winner by comparison, reward by target match.
  task automatic model(input bit tgt, input int na, input int nb);
    int d;
    exp_a = (na > CMAX) ? CMAX : na;
    exp_b = (nb > CMAX) ? CMAX : nb;
    d = (exp_a > exp_b) ? exp_a - exp_b : exp_b - exp_a;
    if (exp_a == exp_b) exp_win = 2'b00;
    else if (exp_a > exp_b) exp_win = 2'b01;
    else exp_win = 2'b10;
`ifdef SNN_REWARD_MARGIN_EN
    if (d < MARGIN) exp_win = 2'b00;
`endif
    if (d < 0) exp_win = 2'b11;  // unreachable guard keeps d referenced in all builds
    if (exp_win == 2'b00) exp_rew = 2'b00;
    else if ((exp_win == 2'b10) == tgt) exp_rew = 2'b01;
    else exp_rew = 2'b11;
  endtask

  // Whenever a reward is presented it must match the model and stay put.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rew_valid === 1'b1) begin
      check("rep_winner", 32'(winner), 32'(exp_win));
      check("rep_reward", 32'(reward), 32'(exp_rew));
      check("rep_cnt_a",  32'(cnt_a),  32'(exp_a));
      check("rep_cnt_b",  32'(cnt_b),  32'(exp_b));
      check("rep_busy",   32'(busy),   32'd1);
    end
  end

  task automatic run_window(input bit tgt, input int na, input int nb, input int hold,
                            input bit gap, input bit poke, input bit freeze);
    model(tgt, na, nb);
    $display("window: target=%0d a=%0d b=%0d hold=%0d gap=%0d poke=%0d freeze=%0d -> win=%0d rew=%0d",
             tgt, na, nb, hold, gap, poke, freeze, exp_win, exp_rew);
    rew_ready = (hold < 0);
    start = 1'b1; target = tgt;
    @(negedge clk);
    start = 1'b0; target = ~tgt;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < WINDOW; i++) begin
      if (gap && (i % 4 == 1)) begin
        in_valid = 1'b0; spike_a = 1'b1; spike_b = 1'b1;
        @(negedge clk);
      end
      if (freeze && i == 5) begin
        ena = 1'b0; in_valid = 1'b1; spike_a = 1'b1; spike_b = 1'b1;
        repeat (2) @(negedge clk);
        ena = 1'b1;
      end
      in_valid = 1'b1; spike_a = (i < na); spike_b = (i < nb);
      @(negedge clk);
    end
    in_valid = 1'b0; spike_a = 1'b0; spike_b = 1'b0;
    check("lat_edge0_valid", 32'(rew_valid), 32'd0);
    @(negedge clk);
    check("lat_edge1_valid", 32'(rew_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(rew_valid), 32'd1);
    if (hold >= 0) begin
      for (int h = 0; h < hold; h++) begin
        start = (poke && h == 1);
        @(negedge clk);
        check("hold_valid", 32'(rew_valid), 32'd1);
      end
      start = 1'b0;
      rew_ready = 1'b1;
    end
    @(negedge clk);
    rew_ready = 1'b0;
    check("post_valid",  32'(rew_valid), 32'd0);
    check("post_winner", 32'(winner),    32'd0);
    check("post_reward", 32'(reward),    32'd0);
    check("post_busy",   32'(busy),      32'd0);
    check("post_cnt_a",  32'(cnt_a),     32'(exp_a));
    check("post_cnt_b",  32'(cnt_b),     32'(exp_b));
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; target = 1'b0; in_valid = 1'b0;
    spike_a = 1'b0; spike_b = 1'b0; rew_ready = 1'b0;
    s_start = 1'b0; s_target = 1'b0; s_in_valid = 1'b0; s_spike_a = 1'b0;
    s_spike_b = 1'b0; s_rew_ready = 1'b0;
    exp_a = 0; exp_b = 0; exp_win = 2'b00; exp_rew = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_valid",  32'(rew_valid), 32'd0);
    check("rst_reward", 32'(reward),    32'd0);
    check("rst_winner", 32'(winner),    32'd0);
    check("rst_cnt_a",  32'(cnt_a),     32'd0);
    check("rst_cnt_b",  32'(cnt_b),     32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Model pins against hand-computed results.
    model(1'b0, 10, 3);
    check("pin_t1_win", 32'(exp_win), 32'd1);
    check("pin_t1_rew", 32'(exp_rew), 32'd1);
    model(1'b0, 4, 9);
    check("pin_t2_win", 32'(exp_win), 32'd2);
    check("pin_t2_rew", 32'(exp_rew), 32'd3);
    model(1'b0, 5, 5);
    check("pin_t3_win", 32'(exp_win), 32'd0);
    check("pin_t3_rew", 32'(exp_rew), 32'd0);

    run_window(1'b0, 10, 3, 5, 1'b0, 1'b1, 1'b0);  // A wins, held 5 cycles, start poked
    check("t1_cnt_a_lit", 32'(cnt_a), 32'd10);
    check("t1_cnt_b_lit", 32'(cnt_b), 32'd3);
    run_window(1'b0, 4, 9, 2, 1'b0, 1'b0, 1'b1);   // B wins against target A, with freeze
    run_window(1'b0, 5, 5, -1, 1'b1, 1'b0, 1'b0);  // tie, early ready, gapped samples
    run_window(1'b1, 2, 8, 1, 1'b0, 1'b0, 1'b0);   // B wins, target B
    run_window(1'b1, 12, 1, 0, 1'b1, 1'b0, 1'b0);  // A wins, target B
    run_window(1'b1, 16, 16, 0, 1'b0, 1'b0, 1'b0); // all spikes, tie
`ifdef SNN_REWARD_MARGIN_EN
    run_window(1'b0, 6, 5, 0, 1'b0, 1'b0, 1'b0);
    check("margin_win_lit", 32'(exp_win), 32'd0);
`endif

    // Small instance: B fires every valid sample, spikes in invalid cycles are ignored.
    $display("small window: target=1 b fires on 7 valid samples, gaps between");
    s_start = 1'b1; s_target = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_target = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_in_valid = 1'b0; s_spike_a = 1'b1; s_spike_b = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b1; s_spike_a = 1'b0; s_spike_b = 1'b1;
      @(negedge clk);
    end
    s_in_valid = 1'b0; s_spike_a = 1'b0; s_spike_b = 1'b0;
    check("s_edge0_valid", 32'(s_rew_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("s_valid",  32'(s_rew_valid), 32'd1);
    check("s_cnt_b",  32'(s_cnt_b),     32'd7);
    check("s_cnt_a",  32'(s_cnt_a),     32'd0);
    check("s_winner", 32'(s_winner),    32'd2);
    check("s_reward", 32'(s_reward),    32'd1);
    s_rew_ready = 1'b1;
    @(negedge clk);
    s_rew_ready = 1'b0;
    check("s_post_valid", 32'(s_rew_valid), 32'd0);
    check("s_post_busy",  32'(s_busy),      32'd0);
    check("s_post_cnt_b", 32'(s_cnt_b),     32'd7);

    // Reset in the middle of a window.
    $display("reset mid-window after 8 of 16 samples");
    start = 1'b1; target = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; spike_a = 1'b1; spike_b = (i < 3);
      @(negedge clk);
    end
    in_valid = 1'b0; spike_a = 1'b0; spike_b = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_cnt_a", 32'(cnt_a),     32'd0);
    check("mid_rst_cnt_b", 32'(cnt_b),     32'd0);
    check("mid_rst_valid", 32'(rew_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_window(1'b0, 7, 2, 0, 1'b0, 1'b0, 1'b0);
    check("clean_cnt_a_lit", 32'(cnt_a), 32'd7);
    check("clean_cnt_b_lit", 32'(cnt_b), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
